if_buf: RTL and testbench

Two-entry instruction buffer between the fetch stage (`ifu`) and decode. It captures the fetched instruction, its address and the branch prediction (taken flag and predicted target) using a valid/ready handshake. It holds them while decode is stalled and discards them on a pipeline flush. It decouples a fetch bus that returns late or bursty from a decode stage that can stall, and it sustains one instruction per cycle when neither side stalls.

---
 rtl/if_buf.sv | 88 ++++++++
 tb/tb_if_buf.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_buf.sv
// Two-entry instruction buffer between fetch and decode.
// Holds fetched instruction, PC and branch prediction across decode stalls; flush discards everything.
module if_buf #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h00000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        if_valid_i,
    output logic        if_ready_o,
    input  logic [31:0] if_inst_i,
    input  logic [31:0] if_inst_addr_i,
    input  logic        if_prdt_taken_i,
    input  logic [31:0] if_prdt_addr_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_inst_addr_o,
    output logic        id_prdt_taken_o,
    output logic [31:0] id_prdt_addr_o
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [31:0] inst_q  [2];
    logic [31:0] addr_q  [2];
    logic        taken_q [2];
    logic [31:0] tgt_q   [2];

    logic       wp_q, wp_d;
    logic       rp_q, rp_d;
    logic [1:0] cnt_q, cnt_d;
    logic       push, pop;

    assign if_ready_o = (cnt_q != FULL);
    assign id_valid_o = (cnt_q != 2'd0);

    assign push = if_valid_i & if_ready_o & ~flush_i;
    assign pop  = id_valid_o & id_ready_i & ~flush_i;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wp_d  = 1'b0;
            rp_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (push) wp_d = ~wp_q;
            if (pop)  rp_d = ~rp_q;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage is deliberately not reset; the empty-forcing below hides stale data.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wp_q]  <= if_inst_i;
            addr_q[wp_q]  <= if_inst_addr_i;
            taken_q[wp_q] <= if_prdt_taken_i;
            tgt_q[wp_q]   <= if_prdt_addr_i;
        end
    end

    assign id_inst_o       = id_valid_o ? inst_q[rp_q]  : NOP_INST;
    assign id_inst_addr_o  = id_valid_o ? addr_q[rp_q]  : 32'd0;
    assign id_prdt_taken_o = id_valid_o ? taken_q[rp_q] : 1'b0;
    assign id_prdt_addr_o  = id_valid_o ? tgt_q[rp_q]   : 32'd0;

endmodule

// File: tb/tb_if_buf.sv
// Self-checking bench for if_buf: a queue model of the buffer tracks expected head and flow control.
module tb_if_buf;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        taken;
        logic [31:0] tgt;
    } entry_t;

    localparam entry_t EMPTY = '{inst: 32'h00000001, addr: 32'd0, taken: 1'b0, tgt: 32'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        ifValid = 1'b0;
    logic        ifReady;
    logic [31:0] ifInst = '0;
    logic [31:0] ifAddr = '0;
    logic        ifTaken = 1'b0;
    logic [31:0] ifTgt = '0;
    logic        idValid;
    logic        idReady = 1'b0;
    logic [31:0] idInst;
    logic [31:0] idAddr;
    logic        idTaken;
    logic [31:0] idTgt;

    int checks = 0;
    int failures = 0;
    entry_t sb[$];

    if_buf dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush),
        .if_valid_i     (ifValid),
        .if_ready_o     (ifReady),
        .if_inst_i      (ifInst),
        .if_inst_addr_i (ifAddr),
        .if_prdt_taken_i(ifTaken),
        .if_prdt_addr_i (ifTgt),
        .id_valid_o     (idValid),
        .id_ready_i     (idReady),
        .id_inst_o      (idInst),
        .id_inst_addr_o (idAddr),
        .id_prdt_taken_o(idTaken),
        .id_prdt_addr_o (idTgt)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and update the scoreboard with what the buffer should accept/deliver.
    task automatic tick();
        bit     doPush, doPop;
        entry_t e;
        doPush = ifValid && (sb.size() != 2) && !flush;
        doPop  = (sb.size() != 0) && idReady && !flush;
        e = '{inst: ifInst, addr: ifAddr, taken: ifTaken, tgt: ifTgt};
        @(posedge clk);
        if (!rst || flush) begin
            sb.delete();
        end else begin
            if (doPop)  void'(sb.pop_front());
            if (doPush) sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit tk, input logic [31:0] tg);
        ifValid = v;
        ifAddr  = pc;
        ifInst  = pc ^ 32'hA5A5_0000;
        ifTaken = tk;
        ifTgt   = tg;
    endtask

    task automatic test_reset();
        entry_t exp, got;
        rst = 1'b0;
        drive(1'b1, 32'h50, 1'b0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            tick();
            got = '{inst: idInst, addr: idAddr, taken: idTaken, tgt: idTgt};
            checks++;
            if (idValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", idValid); end
            checks++;
            if (ifReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", ifReady); end
            checks++;
            if (got !== EMPTY) begin failures++; $display("[TB] FAIL reset_payload: got %h expected %h", got, EMPTY); end
        end
        rst = 1'b1;
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        exp = (sb.size() != 0) ? sb[0] : EMPTY;
        got = '{inst: idInst, addr: idAddr, taken: idTaken, tgt: idTgt};
        checks++;
        if (idValid !== 1'b1 || idAddr !== 32'h50) begin
            failures++; $display("[TB] FAIL reset_first_push: got v=%b addr=%h expected v=1 addr=00000050", idValid, idAddr);
        end
        checks++;
        if (got !== exp) begin failures++; $display("[TB] FAIL reset_first_head: got %h expected %h", got, exp); end
        idReady = 1'b1;
        tick();
        idReady = 1'b0;
    endtask

    task automatic test_streaming();
        entry_t exp, got;
        idReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, 32'(i * 4), 1'b0, 32'h0);
            else       drive(1'b0, 32'h0, 1'b0, 32'h0);
            tick();
            exp = (sb.size() != 0) ? sb[0] : EMPTY;
            got = '{inst: idInst, addr: idAddr, taken: idTaken, tgt: idTgt};
            checks++;
            if (ifReady !== 1'b1) begin failures++; $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", i, ifReady); end
            checks++;
            if (got !== exp || idValid !== (sb.size() != 0)) begin
                failures++; $display("[TB] FAIL stream_head[%0d]: got v=%b %h expected %h", i, idValid, got, exp);
            end
            if (i < 4) begin
                checks++;
                if (idAddr !== 32'(i * 4)) begin failures++; $display("[TB] FAIL stream_addr[%0d]: got %h expected %h", i, idAddr, i * 4); end
            end
        end
        idReady = 1'b0;
    endtask

    task automatic test_stall_fill();
        entry_t got;
        idReady = 1'b0;
        drive(1'b1, 32'h100, 1'b1, 32'h200);
        tick();
        checks++;
        if (ifReady !== 1'b1) begin failures++; $display("[TB] FAIL stall_ready1: got %b expected 1", ifReady); end
        drive(1'b1, 32'h104, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h108, 1'b0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            got = '{inst: idInst, addr: idAddr, taken: idTaken, tgt: idTgt};
            checks++;
            if (ifReady !== 1'b0) begin failures++; $display("[TB] FAIL stall_full[%0d]: got %b expected 0", c, ifReady); end
            checks++;
            if (got !== sb[0] || idAddr !== 32'h100 || idTaken !== 1'b1 || idTgt !== 32'h200) begin
                failures++; $display("[TB] FAIL stall_head[%0d]: got %h expected %h", c, got, sb[0]);
            end
            if (c == 0) tick();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        idReady = 1'b1;
        tick();
        checks++;
        if (ifReady !== 1'b1 || idAddr !== 32'h104 || idTaken !== 1'b0) begin
            failures++; $display("[TB] FAIL stall_drain1: got rdy=%b addr=%h expected rdy=1 addr=00000104", ifReady, idAddr);
        end
        tick();
        checks++;
        if (idValid !== 1'b0 || sb.size() != 0) begin
            failures++; $display("[TB] FAIL stall_drain2: got v=%b expected 0 (108 must not be delivered)", idValid);
        end
        idReady = 1'b0;
    endtask

    task automatic test_flush();
        entry_t got;
        idReady = 1'b0;
        drive(1'b1, 32'h280, 1'b0, 32'h0); tick();
        drive(1'b1, 32'h284, 1'b0, 32'h0); tick();
        checks++;
        if (ifReady !== 1'b0) begin failures++; $display("[TB] FAIL flush_prefull: got %b expected 0", ifReady); end
        idReady = 1'b1;
        flush   = 1'b1;
        drive(1'b1, 32'h300, 1'b0, 32'h0);
        tick();
        flush   = 1'b0;
        idReady = 1'b0;
        got = '{inst: idInst, addr: idAddr, taken: idTaken, tgt: idTgt};
        checks++;
        if (idValid !== 1'b0 || ifReady !== 1'b1 || got !== EMPTY) begin
            failures++; $display("[TB] FAIL flush_empty: got v=%b rdy=%b %h expected v=0 rdy=1 %h", idValid, ifReady, got, EMPTY);
        end
        drive(1'b1, 32'h400, 1'b1, 32'h480);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        got = '{inst: idInst, addr: idAddr, taken: idTaken, tgt: idTgt};
        checks++;
        if (idValid !== 1'b1 || sb.size() != 1 || got !== sb[0] || idAddr !== 32'h400) begin
            failures++; $display("[TB] FAIL flush_next_push: got v=%b %h expected addr 00000400", idValid, got);
        end
        idReady = 1'b1;
        tick();
        idReady = 1'b0;
    endtask

    task automatic test_wrap();
        entry_t exp, got;
        int pushed = 0;
        int popped = 0;
        for (int c = 0; c < 16 && popped < 5; c++) begin
            if (pushed < 5) drive(1'b1, 32'h500 + 32'(pushed * 4), 1'b0, 32'(pushed));
            else            drive(1'b0, 32'h0, 1'b0, 32'h0);
            idReady = (c % 2 == 1);
            if (idValid && idReady) begin
                checks++;
                if (idAddr !== 32'h500 + 32'(popped * 4)) begin
                    failures++; $display("[TB] FAIL wrap_order[%0d]: got %h expected %h", popped, idAddr, 32'h500 + 32'(popped * 4));
                end
                popped++;
            end
            if (ifValid && ifReady) pushed++;
            tick();
            exp = (sb.size() != 0) ? sb[0] : EMPTY;
            got = '{inst: idInst, addr: idAddr, taken: idTaken, tgt: idTgt};
            checks++;
            if (got !== exp || ifReady !== (sb.size() != 2) || idValid !== (sb.size() != 0)) begin
                failures++; $display("[TB] FAIL wrap_state[%0d]: got v=%b rdy=%b %h expected %h", c, idValid, ifReady, got, exp);
            end
        end
        checks++;
        if (popped != 5) begin failures++; $display("[TB] FAIL wrap_count: got %0d expected 5", popped); end
        idReady = 1'b0;
    endtask

    task automatic test_reset_mid();
        entry_t got;
        idReady = 1'b0;
        drive(1'b1, 32'h600, 1'b1, 32'h700);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (idValid !== 1'b1 || idAddr !== 32'h600) begin
            failures++; $display("[TB] FAIL rstmid_held: got v=%b addr=%h expected v=1 addr=00000600", idValid, idAddr);
        end
        rst = 1'b0;
        idReady = 1'b1;
        tick();
        rst = 1'b1;
        idReady = 1'b0;
        got = '{inst: idInst, addr: idAddr, taken: idTaken, tgt: idTgt};
        checks++;
        if (idValid !== 1'b0 || ifReady !== 1'b1 || got !== EMPTY) begin
            failures++; $display("[TB] FAIL rstmid_empty: got v=%b rdy=%b %h expected v=0 rdy=1 %h", idValid, ifReady, got, EMPTY);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_streaming();
        test_stall_fill();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
